md_unit: RTL and testbench

- Multiply/divide unit in the EX stage of the pipelined MIPS core.
- Sits beside the ALU and takes the same forwarded A/B operands.
- Its read data is muxed with the ALU result into the EX/MEM register.
- Implements MULT/MULTU/DIV/DIVU with fixed multi-cycle latency, owns the HI/LO registers, and serves MFHI/MFLO/MTHI/MTLO. Its busy output drives the hazard unit's stall of later HI/LO users.

---
 rtl/md_unit_pkg.sv | 24 ++
 rtl/md_unit_if.sv | 28 ++
 rtl/md_unit_compute.sv | 59 +++++
 rtl/md_unit.sv | 90 +++++++++
 tb/tb_md_unit.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/md_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : md_defs (package)
// Brief    : HI/LO-class opcode encodings and default multi-cycle latencies.
// Revision : 1.0 - initial release
// ============================================================================
package md_defs;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_MFHI  = 3'd6,
        MD_MFLO  = 3'd7
    } md_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

endpackage
`default_nettype wire

// File: rtl/md_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : md_if (interface)
// Brief    : EX-stage request/response bundle of the multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
interface md_if;
    logic        md_en;
    logic [2:0]  md_op;
    logic        req;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output md_en, md_op, req, A, B,
        input  busy, rd_data, hi, lo
    );

    modport slave (
        input  md_en, md_op, req, A, B,
        output busy, rd_data, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/md_unit_compute.sv
`default_nettype none
// ============================================================================
// Module   : md_compute
// Brief    : Combinational 64-bit {hi,lo} result for MULT/MULTU/DIV/DIVU.
// Revision : 1.0 - initial release
// ============================================================================
module md_compute (
    input  wire logic [31:0] a,
    input  wire logic [31:0] b,
    input  wire logic [1:0]  op,
    output logic      [63:0] result,
    output logic             div_zero
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_signed_div;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_divisor;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_prod_s = 64'($signed(a)) * 64'($signed(b));
    assign w_prod_u = 64'(a) * 64'(b);

    // Signed divide runs on magnitudes so 0x80000000 / -1 never overflows.
    always_comb begin
        w_signed_div = ~op[0];
        w_a_neg      = w_signed_div & a[31];
        w_b_neg      = w_signed_div & b[31];
        w_a_mag      = w_a_neg ? (32'd0 - a) : a;
        w_b_mag      = w_b_neg ? (32'd0 - b) : b;
        w_divisor    = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
        w_q_mag      = w_a_mag / w_divisor;
        w_r_mag      = w_a_mag % w_divisor;
        w_quot       = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
        w_rem        = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;
    end

    always_comb begin
        result   = 64'd0;
        div_zero = 1'b0;
        case (op)
            2'd0:    result = w_prod_s;
            2'd1:    result = w_prod_u;
            default: begin
                result   = {w_rem, w_quot};
                div_zero = (b == 32'd0);
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module   : md_unit
// Brief    : EX-stage multiply/divide unit owning HI/LO with fixed latency.
// Revision : 1.0 - initial release
// ============================================================================
module md_unit
    import md_defs::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  wire logic clk,
    input  wire logic reset,
    md_if.slave       bus
);

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W        = $clog2(c_MAX_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_hi_nx;
    logic [31:0]      r_lo_nx;
    logic             r_hold;

    logic             w_accept;
    logic [63:0]      w_result;
    logic             w_div_zero;

    assign w_accept = bus.md_en & ~bus.req & ~r_busy;

    md_compute u_compute (
        .a        (bus.A),
        .b        (bus.B),
        .op       (bus.md_op[1:0]),
        .result   (w_result),
        .div_zero (w_div_zero)
    );

    // An in-flight operation always finishes, regardless of req or new md_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_hi_nx <= 32'd0;
            r_lo_nx <= 32'd0;
            r_hold  <= 1'b0;
        end else if (r_cnt != '0) begin
            r_cnt  <= r_cnt - CNT_W'(1);
            r_busy <= (r_cnt != CNT_W'(1));
            if (r_cnt == CNT_W'(1) && !r_hold) begin
                r_hi <= r_hi_nx;
                r_lo <= r_lo_nx;
            end
        end else if (w_accept) begin
            case (bus.md_op)
                MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                    r_cnt   <= bus.md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    r_busy  <= 1'b1;
                    r_hi_nx <= w_result[63:32];
                    r_lo_nx <= w_result[31:0];
                    r_hold  <= w_div_zero;
                end
                MD_MTHI: r_hi <= bus.A;
                MD_MTLO: r_lo <= bus.A;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.rd_data = 32'd0;
        if (bus.md_op == MD_MFHI) begin
            bus.rd_data = r_hi;
        end else if (bus.md_op == MD_MFLO) begin
            bus.rd_data = r_lo;
        end
    end

    assign bus.busy = r_busy;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_unit
// Brief    : Self-checking bench for md_unit against a behavioural HI/LO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_md_unit;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_if bus ();

    md_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.md_en = 1'b0;
        bus.md_op = 3'd0;
        bus.req   = 1'b0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
    endtask

    // Architectural effect of one accepted instruction, from the ISA definition.
    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int latency);
        longint q;
        longint r;
        logic [63:0] p;
        latency = 0;
        case (op)
            3'd0: begin p = longint'($signed(a)) * longint'($signed(b)); {m_hi, m_lo} = p; latency = 5; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; latency = 5; end
            3'd2: begin
                latency = 10;
                if (b != 32'd0) begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
            end
            3'd3: begin
                latency = 10;
                if (b != 32'd0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endtask

    // Issue one accepted instruction and track busy until the result lands.
    task automatic run_op(input string name, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        int lat;
        int n;
        model_op(op, a, b, lat);
        bus.md_en = 1'b1; bus.md_op = op; bus.A = a; bus.B = b; bus.req = 1'b0;
        tick();
        idle();
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n != lat) begin
            failures++;
            $display("FAIL %s busy_cycles actual=%0d required=%0d", name, n, lat);
        end
        checks++;
        if (bus.hi !== m_hi || bus.lo !== m_lo) begin
            failures++;
            $display("FAIL %s hilo actual=%h_%h required=%h_%h", name, bus.hi, bus.lo, m_hi, m_lo);
        end
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        checks++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset actual hi=%h lo=%h busy=%b required 0/0/0", bus.hi, bus.lo, bus.busy);
        end
    endtask

    task automatic test_mult();
        run_op("mult_neg2x3", 3'd0, 32'hFFFF_FFFE, 32'd3);
        checks++;
        if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFA) begin
            failures++;
            $display("FAIL mult_const actual=%h_%h required=ffffffff_fffffffa", bus.hi, bus.lo);
        end
        bus.md_op = 3'd6;
        #1;
        checks++;
        if (bus.rd_data !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL mfhi actual=%h required=ffffffff", bus.rd_data);
        end
        bus.md_op = 3'd7;
        #1;
        checks++;
        if (bus.rd_data !== m_lo) begin
            failures++;
            $display("FAIL mflo actual=%h required=%h", bus.rd_data, m_lo);
        end
        bus.md_op = 3'd4;
        #1;
        checks++;
        if (bus.rd_data !== 32'd0) begin
            failures++;
            $display("FAIL rd_nonmf actual=%h required=0", bus.rd_data);
        end
        idle();
        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++;
        if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin
            failures++;
            $display("FAIL multu_const actual=%h_%h required=fffffffe_00000001", bus.hi, bus.lo);
        end
    endtask

    task automatic test_div();
        run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2);
        checks++;
        if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD) begin
            failures++;
            $display("FAIL div_const actual=%h_%h required=ffffffff_fffffffd", bus.hi, bus.lo);
        end
        run_op("divu_m7_2", 3'd3, 32'hFFFF_FFF9, 32'd2);
        checks++;
        if (bus.hi !== 32'h0000_0001 || bus.lo !== 32'h7FFF_FFFC) begin
            failures++;
            $display("FAIL divu_const actual=%h_%h required=00000001_7ffffffc", bus.hi, bus.lo);
        end
        run_op("mthi", 3'd4, 32'h1234_5678, 32'd0);
        run_op("div_by_zero", 3'd2, 32'd99, 32'd0);
        checks++;
        if (bus.hi !== 32'h1234_5678) begin
            failures++;
            $display("FAIL div0_hold actual=%h required=12345678", bus.hi);
        end
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        checks++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'h8000_0000) begin
            failures++;
            $display("FAIL div_ovf_const actual=%h_%h required=00000000_80000000", bus.hi, bus.lo);
        end
    endtask

    task automatic test_flush();
        int n;
        int lat;
        bus.md_en = 1'b1; bus.md_op = 3'd0; bus.A = 32'd7; bus.B = 32'd9; bus.req = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== m_hi || bus.lo !== m_lo) begin
            failures++;
            $display("FAIL flush_mult actual busy=%b hilo=%h_%h required 0 %h_%h", bus.busy, bus.hi, bus.lo, m_hi, m_lo);
        end
        bus.md_en = 1'b1; bus.md_op = 3'd5; bus.A = 32'hDEAD_BEEF; bus.req = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.lo !== m_lo) begin
            failures++;
            $display("FAIL flush_mtlo actual=%h required=%h", bus.lo, m_lo);
        end
        // req arriving mid-flight belongs to a younger instruction.
        model_op(3'd0, 32'h0001_0003, 32'hFFFF_0005, lat);
        bus.md_en = 1'b1; bus.md_op = 3'd0; bus.A = 32'h0001_0003; bus.B = 32'hFFFF_0005;
        tick();
        idle();
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            bus.req = (n == 2 || n == 4);
            tick();
            n++;
        end
        idle();
        checks++;
        if (n != lat || bus.hi !== m_hi || bus.lo !== m_lo) begin
            failures++;
            $display("FAIL flush_inflight actual n=%0d hilo=%h_%h required n=%0d %h_%h", n, bus.hi, bus.lo, lat, m_hi, m_lo);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        bus.md_en = 1'b1; bus.md_op = 3'd3; bus.A = 32'd1000; bus.B = 32'd7;
        tick();
        idle();
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid actual busy=%b hilo=%h_%h required 0 0_0", bus.busy, bus.hi, bus.lo);
        end
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL reset_late_update actual bad_cycles=%0d required=0", bad);
        end
    endtask

    task automatic test_ignore_busy();
        int n;
        int lat;
        model_op(3'd0, 32'h0000_1234, 32'h0000_5678, lat);
        bus.md_en = 1'b1; bus.md_op = 3'd0; bus.A = 32'h0000_1234; bus.B = 32'h0000_5678;
        tick();
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            bus.md_en = 1'b1;
            bus.md_op = 3'($urandom_range(0, 5));
            bus.A     = $urandom;
            bus.B     = $urandom;
            tick();
            n++;
        end
        idle();
        checks++;
        if (n != lat || bus.hi !== m_hi || bus.lo !== m_lo) begin
            failures++;
            $display("FAIL ignore_busy actual n=%0d hilo=%h_%h required n=%0d %h_%h", n, bus.hi, bus.lo, lat, m_hi, m_lo);
        end
    endtask

    task automatic test_back_to_back();
        run_op("b2b_first", 3'd1, 32'h0000_0010, 32'h0000_0020);
        bus.md_op = 3'd7;
        #1;
        checks++;
        if (bus.rd_data !== m_lo) begin
            failures++;
            $display("FAIL b2b_mflo actual=%h required=%h", bus.rd_data, m_lo);
        end
        idle();
        run_op("b2b_second", 3'd2, 32'hFFFF_FF00, 32'd3);
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 5));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 50));
                3: b = 32'd0 - 32'($urandom_range(1, 50));
                default: ;
            endcase
            run_op("random", op, a, b);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        idle();
        test_reset();
        test_mult();
        test_div();
        test_flush();
        test_reset_mid();
        test_ignore_busy();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
